// File: rtl/nco_config_unit.sv
//==============================================================================
// Module   : nco_config_unit
// Purpose  : Commits panel waveform/frequency selections and runs the NCO
//            phase accumulator. Optional macro FREQ_GLIDE_EN ramps tuning_word.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module nco_config_unit #(
    parameter int ACC_W     = 26,
    parameter int PHASE_W   = 8,
    parameter int TW_STEP   = 6711,
    parameter int GLIDE_DIV = 1000
) (
    input  logic               clk_1MHz,
    input  logic               rst_n,
    input  logic [2:0]         state_in,
    input  logic [1:0]         sw_wave,
    input  logic [3:0]         sw_freq,
    output logic [1:0]         wave_sel,
    output logic [ACC_W-1:0]   tuning_word,
    output logic [PHASE_W-1:0] phase,
    output logic [1:0]         cfg_valid,
    output logic               cfg_update,
    output logic               state_err
);

    localparam logic [2:0]       c_S0   = 3'd0;
    localparam logic [2:0]       c_S1   = 3'd1;
    localparam logic [2:0]       c_S2   = 3'd2;
    localparam logic [2:0]       c_S3   = 3'd3;
    localparam logic [2:0]       c_S4   = 3'd4;
    localparam logic [2:0]       c_S5   = 3'd5;
    localparam logic [ACC_W-1:0] c_STEP = ACC_W'(TW_STEP);

    logic [2:0]       r_prev_state;
    logic [1:0]       r_wave_q;
    logic [3:0]       r_freq_q;
    logic [ACC_W-1:0] r_target;
    logic             r_load;
    logic [ACC_W-1:0] r_acc;

    logic             w_clear;
    logic             w_illegal;
    logic             w_wave_commit;
    logic             w_freq_commit;
    logic [ACC_W-1:0] w_target_calc;
    logic [1:0]       w_wave_next;
    logic [ACC_W-1:0] w_tw_next;
    logic [1:0]       w_valid_next;

    assign w_clear       = (state_in == c_S0);
    assign w_illegal     = (state_in > c_S5);
    assign w_wave_commit = (r_prev_state == c_S1) && (state_in == c_S2);
    assign w_freq_commit = (r_prev_state == c_S3) && (state_in == c_S4);
    assign w_target_calc = (ACC_W'(r_freq_q) + ACC_W'(1)) * c_STEP;
    assign phase         = r_acc[ACC_W-1 -: PHASE_W];

`ifdef FREQ_GLIDE_EN
    localparam int c_DIV_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

    logic [c_DIV_W-1:0] r_div;
    logic               w_glide_tick;

    assign w_glide_tick = (r_div == c_DIV_W'(GLIDE_DIV - 1));

    // Divider restarts on every commit so the first step lands a full period later.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_clear || r_load || w_glide_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end
`endif

    always_comb begin
        w_wave_next  = wave_sel;
        w_tw_next    = tuning_word;
        w_valid_next = cfg_valid;
        if (w_clear) begin
            w_wave_next  = '0;
            w_tw_next    = '0;
            w_valid_next = '0;
        end else begin
            if (w_wave_commit) begin
                w_wave_next     = r_wave_q;
                w_valid_next[0] = 1'b1;
            end
`ifdef FREQ_GLIDE_EN
            if (r_load) begin
                w_valid_next[1] = 1'b1;
            end else if (w_glide_tick) begin
                if (tuning_word < r_target) begin
                    w_tw_next = ((r_target - tuning_word) <= c_STEP) ? r_target
                                                                     : tuning_word + c_STEP;
                end else if (tuning_word > r_target) begin
                    w_tw_next = ((tuning_word - r_target) <= c_STEP) ? r_target
                                                                     : tuning_word - c_STEP;
                end
            end
`else
            if (r_load) begin
                w_tw_next       = r_target;
                w_valid_next[1] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_state <= c_S0;
            r_wave_q     <= '0;
            r_freq_q     <= '0;
            r_target     <= '0;
            r_load       <= 1'b0;
            r_acc        <= '0;
            wave_sel     <= '0;
            tuning_word  <= '0;
            cfg_valid    <= '0;
            cfg_update   <= 1'b0;
            state_err    <= 1'b0;
        end else begin
            r_prev_state <= state_in;
            r_wave_q     <= sw_wave;
            r_freq_q     <= sw_freq;
            r_load       <= w_freq_commit;
            wave_sel     <= w_wave_next;
            tuning_word  <= w_tw_next;
            cfg_valid    <= w_valid_next;
            cfg_update   <= (w_wave_next != wave_sel) || (w_tw_next != tuning_word);

            if (w_clear) begin
                r_target <= '0;
            end else if (w_freq_commit) begin
                r_target <= w_target_calc;
            end

            // Accumulator runs on the registered config so it lags a commit by one cycle.
            if (w_clear) begin
                r_acc <= '0;
            end else if (cfg_valid == 2'b11) begin
                r_acc <= r_acc + tuning_word;
            end

            if (w_clear) begin
                state_err <= 1'b0;
            end else if (w_illegal) begin
                state_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
